// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, state encodings and bit-time math
package uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START     = 4'd1,
    ST_DATA      = 4'd2,
    ST_STOP      = 4'd3,
    ST_WAIT_HIGH = 4'd4
  } state_e;

  // TX and RX both derive their bit period here so they always agree.
  function automatic int unsigned calc_bit_time(input int unsigned sys_clk_hz,
                                                input int unsigned baud);
    return sys_clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop RX synchronizer plus one-flop delay for falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta_q;
  logic rx_s_q;
  logic rx_d_q;

  // Reset to the idle line level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      meta_q <= rx;
      rx_s_q <= meta_q;
      rx_d_q <= rx_s_q;
    end
  end

  assign rx_s = rx_s_q;
  assign fall = rx_d_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-cycle valid and framing-error strobes
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE           = 115200,
  parameter int unsigned SYS_CLOCK_FREQUENCY = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [3:0] probe
);

  localparam int unsigned BIT_TIME  = calc_bit_time(SYS_CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned HALF_TIME = BIT_TIME / 2;
  localparam logic [31:0] BIT_LAST  = 32'(BIT_TIME - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF_TIME - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (RX),
    .rx_s (rx_s),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          timer_d = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (timer_q == HALF_LAST) begin
          // Line back high at mid start bit: a glitch, not a frame.
          if (rx_s != START_BIT) begin
            state_d = ST_IDLE;
          end else begin
            timer_d   = '0;
            bit_idx_d = '0;
            state_d   = ST_DATA;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_DATA: begin
        if (timer_q == BIT_LAST) begin
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          timer_d            = '0;
          if (bit_idx_q == IDX_LAST) state_d = ST_STOP;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_STOP: begin
        if (timer_q == BIT_LAST) begin
          if (rx_s == STOP_BIT) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data      = data_q;
    valid     = valid_q;
    frame_err = ferr_q;
    busy      = (state_q != ST_IDLE);
    probe     = state_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  localparam int BT   = 16;
  localparam int HT   = 8;
  localparam int LAT  = HT + 9 * BT;
  localparam int BT2  = 434;
  localparam int HT2  = 217;
  localparam int LAT2 = HT2 + 9 * BT2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX  = 1'b1;
  logic       RX2 = 1'b1;
  logic [7:0] data, data2;
  logic       valid, valid2, frame_err, frame_err2, busy, busy2;
  logic [3:0] probe, probe2;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0] rx_bytes[$];
  int         rx_cycs[$];
  int         ferr_cnt    = 0;
  int         overlap_cnt = 0;
  int         rx2_cnt     = 0;
  int         rx2_cyc     = 0;
  logic [7:0] rx2_byte    = 8'h00;

  uart_rx #(.BAUD_RATE(1), .SYS_CLOCK_FREQUENCY(16)) u_dut (
    .clk(clk), .rst(rst), .RX(RX), .data(data), .valid(valid),
    .frame_err(frame_err), .busy(busy), .probe(probe)
  );

  uart_rx u_loop (
    .clk(clk), .rst(rst), .RX(RX2), .data(data2), .valid(valid2),
    .frame_err(frame_err2), .busy(busy2), .probe(probe2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      rx_bytes.push_back(data);
      rx_cycs.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) overlap_cnt++;
    if (valid2 && frame_err2) overlap_cnt++;
    if (valid2) begin
      rx2_cnt++;
      rx2_cyc  = cyc;
      rx2_byte = data2;
    end
  end

  task automatic send_bit(input logic b, input int n);
    RX = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0, BT);
    for (int i = 0; i < 8; i++) send_bit(b[i], BT);
    send_bit(stop, BT);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 00", data);
    end
    vectors++;
    if ({valid, frame_err, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected 000", {valid, frame_err, busy});
    end
    vectors++;
    if (probe !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_probe: got %0d expected 0", probe);
    end
    vectors++;
    if ({data2, busy2, probe2} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_loop: got %h expected 0", {data2, busy2, probe2});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int q0, f0, c0;
    q0 = rx_bytes.size();
    f0 = ferr_cnt;
    c0 = cyc;
    send_frame(8'h48, 1'b1);
    repeat (4) @(negedge clk);
    vectors++;
    if (rx_bytes.size() != q0 + 1) begin
      miscompares++;
      $display("FAIL single_count: got %0d pulses expected 1", rx_bytes.size() - q0);
    end
    vectors++;
    if (rx_bytes.size() <= q0 || rx_bytes[q0] !== 8'h48) begin
      miscompares++;
      $display("FAIL single_data: got %h expected 48", data);
    end
    vectors++;
    if (rx_cycs.size() <= q0 || rx_cycs[q0] - c0 < LAT || rx_cycs[q0] - c0 > LAT + 4) begin
      miscompares++;
      $display("FAIL single_latency: got %0d expected %0d..%0d",
               (rx_cycs.size() > q0) ? rx_cycs[q0] - c0 : -1, LAT, LAT + 4);
    end
    vectors++;
    if (ferr_cnt != f0) begin
      miscompares++;
      $display("FAIL single_ferr: got %0d expected 0", ferr_cnt - f0);
    end
    vectors++;
    if ({busy, probe} !== 5'b0) begin
      miscompares++;
      $display("FAIL single_idle: got busy=%b probe=%0d expected 0/0", busy, probe);
    end
  endtask

  task automatic test_back_to_back();
    int q0, f0;
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'hA5;
    q0 = rx_bytes.size();
    f0 = ferr_cnt;
    for (int k = 0; k < 3; k++) send_frame(exp_b[k], 1'b1);
    repeat (4) @(negedge clk);
    vectors++;
    if (rx_bytes.size() != q0 + 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d pulses expected 3", rx_bytes.size() - q0);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rx_bytes.size() <= q0 + k || rx_bytes[q0 + k] !== exp_b[k]) begin
        miscompares++;
        $display("FAIL b2b_data%0d: got %h expected %h", k,
                 (rx_bytes.size() > q0 + k) ? rx_bytes[q0 + k] : 8'hxx, exp_b[k]);
      end
    end
    for (int k = 1; k < 3; k++) begin
      vectors++;
      if (rx_cycs.size() <= q0 + k ||
          rx_cycs[q0 + k] - rx_cycs[q0 + k - 1] < 158 ||
          rx_cycs[q0 + k] - rx_cycs[q0 + k - 1] > 162) begin
        miscompares++;
        $display("FAIL b2b_spacing%0d: got %0d expected 160+-2", k,
                 (rx_cycs.size() > q0 + k) ? rx_cycs[q0 + k] - rx_cycs[q0 + k - 1] : -1);
      end
    end
    vectors++;
    if (ferr_cnt != f0) begin
      miscompares++;
      $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_glitch();
    int q0, f0;
    q0 = rx_bytes.size();
    f0 = ferr_cnt;
    send_bit(1'b0, 3);
    vectors++;
    if (probe !== 4'd1) begin
      miscompares++;
      $display("FAIL glitch_start: got probe=%0d expected 1", probe);
    end
    send_bit(1'b1, 30);
    vectors++;
    if (rx_bytes.size() != q0 || ferr_cnt != f0) begin
      miscompares++;
      $display("FAIL glitch_pulses: got valid=%0d ferr=%0d expected 0/0",
               rx_bytes.size() - q0, ferr_cnt - f0);
    end
    vectors++;
    if ({data, probe} !== {8'hA5, 4'd0}) begin
      miscompares++;
      $display("FAIL glitch_state: got data=%h probe=%0d expected A5/0", data, probe);
    end
  endtask

  task automatic test_frame_err();
    int q0, f0;
    q0 = rx_bytes.size();
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    send_bit(1'b0, 50);
    vectors++;
    if (probe !== 4'd4) begin
      miscompares++;
      $display("FAIL ferr_wait: got probe=%0d expected 4", probe);
    end
    vectors++;
    if (ferr_cnt != f0 + 1) begin
      miscompares++;
      $display("FAIL ferr_count: got %0d pulses expected 1", ferr_cnt - f0);
    end
    send_bit(1'b0, 50);
    vectors++;
    if ({busy, probe} !== {1'b1, 4'd4}) begin
      miscompares++;
      $display("FAIL ferr_hold: got busy=%b probe=%0d expected 1/4", busy, probe);
    end
    send_bit(1'b1, 10);
    vectors++;
    if ({busy, probe} !== 5'b0) begin
      miscompares++;
      $display("FAIL ferr_idle: got busy=%b probe=%0d expected 0/0", busy, probe);
    end
    vectors++;
    if (rx_bytes.size() != q0 || ferr_cnt != f0 + 1 || data !== 8'hA5) begin
      miscompares++;
      $display("FAIL ferr_after: got valid=%0d ferr=%0d data=%h expected 0/1/A5",
               rx_bytes.size() - q0, ferr_cnt - f0, data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int q0, f0;
    q0 = rx_bytes.size();
    f0 = ferr_cnt;
    send_bit(1'b0, BT);
    send_bit(1'b0, BT);
    send_bit(1'b0, BT);
    send_bit(1'b1, 5);
    vectors++;
    if (probe !== 4'd2) begin
      miscompares++;
      $display("FAIL rstmid_data_state: got probe=%0d expected 2", probe);
    end
    rst = 1'b1;
    RX  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy, probe, data} !== 13'h0) begin
      miscompares++;
      $display("FAIL rstmid_cleared: got busy=%b probe=%0d data=%h expected 0/0/00",
               busy, probe, data);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (rx_bytes.size() != q0 || ferr_cnt != f0) begin
      miscompares++;
      $display("FAIL rstmid_pulses: got valid=%0d ferr=%0d expected 0/0",
               rx_bytes.size() - q0, ferr_cnt - f0);
    end
    send_frame(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    vectors++;
    if (rx_bytes.size() != q0 + 1 || data !== 8'hC3) begin
      miscompares++;
      $display("FAIL rstmid_next: got pulses=%0d data=%h expected 1/C3",
               rx_bytes.size() - q0, data);
    end
  endtask

  task automatic test_loopback();
    int c0, n0;
    logic [7:0] b;
    b  = 8'h48;
    n0 = rx2_cnt;
    c0 = cyc;
    RX2 = 1'b0;
    repeat (BT2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX2 = b[i];
      repeat (BT2) @(negedge clk);
    end
    RX2 = 1'b1;
    repeat (BT2 + 10) @(negedge clk);
    vectors++;
    if (rx2_cnt != n0 + 1 || rx2_byte !== 8'h48) begin
      miscompares++;
      $display("FAIL loop_data: got pulses=%0d data=%h expected 1/48", rx2_cnt - n0, rx2_byte);
    end
    vectors++;
    if (rx2_cyc - c0 < LAT2 || rx2_cyc - c0 > LAT2 + 4) begin
      miscompares++;
      $display("FAIL loop_latency: got %0d expected %0d..%0d", rx2_cyc - c0, LAT2, LAT2 + 4);
    end
    vectors++;
    if (overlap_cnt != 0) begin
      miscompares++;
      $display("FAIL valid_ferr_overlap: got %0d expected 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream counterpart of the team's UART transmitter.
- Samples the incoming serial line and recovers 8N1 frames: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity.
- Presents each byte on a parallel bus with a one-cycle valid strobe.
- Flags framing errors.
- Sits between the board RX pin and the byte consumer (command parser / loopback).

Parameters:
BAUD_RATE, 115200, serial bit rate in bit/s
SYS_CLOCK_FREQUENCY, 50000000, clk frequency in Hz
(derived localparam) BIT_TIME = SYS_CLOCK_FREQUENCY/BAUD_RATE (434 at defaults); HALF_TIME = BIT_TIME/2 (217)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
RX  input  1  asynchronous serial line; idles high
data  output  8  last correctly received byte
valid  output  1  one-cycle pulse; data updated in the same cycle
frame_err  output  1  one-cycle pulse; stop bit sampled low
busy  output  1  high whenever state is not IDLE
probe  output  4  current state encoding, for debug

Behaviour:
- Reset: one clock, synchronous, active-high. Sampled on the clk edge, rst=1 gives:
  - state=IDLE, timer=0, bit_idx=0, shift register=0;
  - data=8'h00, valid=0, frame_err=0, busy=0;
  - synchronizer flops=1.
- Reset mid-frame aborts the frame with no valid or frame_err pulse. rst has priority over all other events.
- Input path: RX passes through a two-flop synchronizer (rx_s), then a one-flop delay (rx_d) for edge detection. Falling edge = rx_d=1 & rx_s=0.
- States (4-bit encodings): IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4. Any other code returns to IDLE next cycle.
- IDLE:
  - On a falling edge: timer<=0, go to START.
  - Otherwise hold.
- START:
  - timer increments each cycle.
  - At timer==HALF_TIME-1: if rx_s=1, treat as a glitch and return to IDLE with no pulse.
  - Else timer<=0, bit_idx<=0, go to DATA.
- DATA:
  - At each timer==BIT_TIME-1: shift_reg[bit_idx]<=rx_s, bit_idx++, timer<=0.
  - After the 8th sample (bit_idx was 7): go to STOP.
- STOP: at timer==BIT_TIME-1 (mid stop bit):
  - rx_s=1: data<=shift_reg, valid=1 for exactly one cycle, go to IDLE.
  - rx_s=0: frame_err=1 for one cycle, data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This covers break conditions and means a held-low line never produces repeated frames.
- Timing:
  - valid rises HALF_TIME + 9*BIT_TIME cycles after the falling edge is detected.
  - Total from the RX pin edge ≤ HALF_TIME + 9*BIT_TIME + 4 cycles.
- Back-to-back frames:
  - Returning to IDLE at mid stop bit lets the next start edge be caught with zero idle gap.
  - rx_d is still updated in STOP, so an edge coinciding with the IDLE entry cycle is detected one cycle later.
- No buffering: the consumer must capture data on valid. data holds its value until the next good frame.
- valid and frame_err are never high together.
- Widths: timer is 32-bit unsigned and compares for equality only; bit_idx is 3-bit plus a terminal check.

Decomposition:
- Shared package uart_pkg:
  - START_BIT=1'b0, STOP_BIT=1'b1, DATA_BITS=8;
  - the state encodings above;
  - a BIT_TIME calculation used by both TX and RX so the two blocks cannot disagree.
- One sub-module, uart_rx_sync: two-flop synchronizer plus edge-detect delay. Reset value 1. Outputs rx_s and fall.
- The FSM, timer and shift register stay in uart_rx.

Test Plan:
Parameters for sim: SYS_CLOCK_FREQUENCY=16, BAUD_RATE=1 (BIT_TIME=16, HALF_TIME=8).
1. Drive byte 8'h48 as a 16-cycle-per-bit 8N1 waveform -> exactly one valid pulse, data=8'h48, frame_err never high, busy low again after the pulse.
2. Bytes 8'h00, 8'hFF, 8'hA5 back-to-back, zero idle bits -> three valid pulses in order with matching data, consecutive pulses 160±2 cycles apart.
3. RX low for 3 cycles then high -> START rejects the glitch, back to IDLE, no valid, no frame_err, data unchanged.
4. Frame 8'h55 with stop bit driven 0, then RX held low 100 cycles, then high -> one frame_err pulse, no valid, state stays WAIT_HIGH (probe=4) while low, data keeps its previous value, then IDLE.
5. rst=1 for 1 cycle during DATA of byte 8'h3C -> next cycle busy=0, probe=0, data=8'h00, no pulses. A following clean frame 8'hC3 is received correctly.
6. Loopback of the UART transmitter TX into RX at default parameters, sending 8'h48 -> valid with data=8'h48 within HALF_TIME+9*BIT_TIME+4 cycles of the TX start-bit edge.
